// File: rtl/mem_module_pkg.sv
// mem_module_pkg: opcodes, exbus/wbbus field layout and FSM encoding for the memory stage
package mem_module_pkg;
    localparam int EXBUS_W    = 40;
    localparam int WBBUS_W    = 20;
    localparam int EX_VALID   = 39;
    localparam int EX_OP_HI   = 38;
    localparam int EX_OP_LO   = 35;
    localparam int EX_DEST_HI = 34;
    localparam int EX_DEST_LO = 32;
    localparam int EX_RES_HI  = 31;
    localparam int EX_RES_LO  = 16;
    localparam int EX_STV_HI  = 15;
    localparam int EX_STV_LO  = 0;
    localparam int WB_VALID   = 19;
    localparam int WB_DEST_HI = 18;
    localparam int WB_DEST_LO = 16;
    localparam int WB_RES_HI  = 15;
    localparam int WB_RES_LO  = 0;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SL   = 4'd6;
    localparam logic [3:0] OP_SR   = 4'd7;
    localparam logic [3:0] OP_SRU  = 4'd8;
    localparam logic [3:0] OP_ADDI = 4'd9;
    localparam logic [3:0] OP_LD   = 4'd10;
    localparam logic [3:0] OP_ST   = 4'd11;
    localparam logic [3:0] OP_BR   = 4'd12;

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    // Ops ADD..ADDI carry their execute result straight to writeback
    function automatic logic is_alu_op(input logic [3:0] op);
        return op >= OP_ADD && op <= OP_ADDI;
    endfunction
endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts ACCESS cycles without ack and flags when the abort point is reached
//   clock, resetn : pipeline clock, async active-low reset
//   i_clear       : entering ACCESS, restart the count
//   i_inc         : an ACCESS cycle passed without ack
//   o_expire      : count has reached TIMEOUT_CYCLES-1
module mem_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expire
);
    logic [7:0] r_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_cnt <= '0;
        else if (i_clear) r_cnt <= '0;
        else if (i_inc) r_cnt <= r_cnt + 8'd1;
    end

    assign o_expire = r_cnt == 8'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/mem_module.sv
// mem_module: memory-access stage performing LD/ST over a req/ack handshake with a registered writeback
//   clock, resetn          : pipeline clock, async active-low reset
//   exbus[39:0]            : {valid, op, dest, exresult, stvalue} from execute
//   stall, mem_dest        : upstream hold request and hazard-detect destination
//   dmem_req/we/addr/wdata : data-memory request, driven from the held exbus
//   dmem_rdata, dmem_ack   : load data and single-cycle completion pulse
//   wbbus[19:0]            : registered {valid, dest, result} to register file
//   mem_err                : sticky access-timeout flag
// Optional feature MEM_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES unacked ACCESS cycles.
module mem_module
    import mem_module_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [EXBUS_W-1:0] exbus,
    output logic               stall,
    output logic [2:0]         mem_dest,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [15:0]        dmem_addr,
    output logic [15:0]        dmem_wdata,
    input  logic [15:0]        dmem_rdata,
    input  logic               dmem_ack,
    output logic [WBBUS_W-1:0] wbbus,
    output logic               mem_err
);
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_module: TIMEOUT_CYCLES must be in 2..255");
    end

    logic               w_valid;
    logic [3:0]         w_op;
    logic [2:0]         w_dest;
    logic [15:0]        w_exres;
    logic [15:0]        w_stv;
    logic               w_is_mem;
    logic               w_expire;
    logic               w_stall;
    logic [WBBUS_W-1:0] w_wb_next;
    state_t             r_state;
    state_t             w_next;
    logic [WBBUS_W-1:0] r_wb;

    assign w_valid  = exbus[EX_VALID];
    assign w_op     = exbus[EX_OP_HI:EX_OP_LO];
    assign w_dest   = exbus[EX_DEST_HI:EX_DEST_LO];
    assign w_exres  = exbus[EX_RES_HI:EX_RES_LO];
    assign w_stv    = exbus[EX_STV_HI:EX_STV_LO];
    assign w_is_mem = w_valid && (w_op == OP_LD || w_op == OP_ST);

`ifdef MEM_TIMEOUT_EN
    logic r_err;

    mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clock    (clock),
        .resetn   (resetn),
        .i_clear  (r_state == ST_IDLE && w_next == ST_ACCESS),
        .i_inc    (r_state == ST_ACCESS && !dmem_ack),
        .o_expire (w_expire)
    );

    // An ack in the abort cycle completes normally, so only an unacked expiry sets the flag
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_err <= 1'b0;
        else r_err <= r_err | (r_state == ST_ACCESS && !dmem_ack && w_expire);
    end

    assign mem_err = r_err;
`else
    assign w_expire = 1'b0;
    assign mem_err  = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_wb_next = '0;
        if (r_state == ST_IDLE) begin
            if (w_is_mem) begin
                w_stall = 1'b1;
                w_next  = ST_ACCESS;
            end else if (w_valid && is_alu_op(w_op)) begin
                w_wb_next = {1'b1, w_dest, w_exres};
            end
        end else if (dmem_ack) begin
            w_next    = ST_IDLE;
            w_wb_next = (w_op == OP_LD) ? {1'b1, w_dest, dmem_rdata} : '0;
        end else if (w_expire) begin
            w_next = ST_IDLE;
        end else begin
            w_stall = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_wb    <= '0;
        end else begin
            r_state <= w_next;
            r_wb    <= w_wb_next;
        end
    end

    // Reset forces stall low even when a memory op is already waiting on exbus
    assign stall      = resetn & w_stall;
    assign mem_dest   = w_dest;
    assign dmem_req   = r_state == ST_ACCESS;
    assign dmem_we    = w_op == OP_ST;
    assign dmem_addr  = w_exres;
    assign dmem_wdata = w_stv;
    assign wbbus      = r_wb;
endmodule

// File: tb/tb_mem_module.sv
// tb_mem_module: randomized self-checking bench for mem_module against a cycle-level reference model
module tb_mem_module;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [39:0] exbus = '0;
    logic [15:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic        stall;
    logic [2:0]  mem_dest;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [19:0] wbbus;
    logic        mem_err;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [19:0] exp_wb = '0;
    logic        exp_err = 1'b0;

    always #5 clock = ~clock;

    mem_module #(.TIMEOUT_CYCLES(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .exbus      (exbus),
        .stall      (stall),
        .mem_dest   (mem_dest),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .wbbus      (wbbus),
        .mem_err    (mem_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_regs();
        check("wbbus", {12'h0, wbbus}, {12'h0, exp_wb});
        check("mem_err", {31'h0, mem_err}, {31'h0, exp_err});
    endtask

    // One instruction: an IDLE cycle, then for LD/ST (delay+1) ACCESS cycles with ack on the last
    task automatic run_op(input logic v, input logic [3:0] op, input logic [2:0] dest,
                          input logic [15:0] res, input logic [15:0] stv, input int delay);
        logic        mem;
        logic [15:0] rd;
        mem = v && (op == 4'd10 || op == 4'd11);
        @(negedge clock);
        exbus    = {v, op, dest, res, stv};
        dmem_ack = 1'($urandom_range(0, 1));
        #1;
        check_regs();
        check("stall_idle", {31'h0, stall}, {31'h0, mem});
        check("req_idle", {31'h0, dmem_req}, 32'h0);
        check("mem_dest", {29'h0, mem_dest}, {29'h0, dest});
        exp_wb = (v && op >= 4'd1 && op <= 4'd9) ? {1'b1, dest, res} : 20'h0;
        if (mem) begin
            for (int k = 0; k <= delay; k++) begin
                @(negedge clock);
                rd         = 16'($urandom);
                dmem_rdata = rd;
                dmem_ack   = (k == delay);
                #1;
                check_regs();
                check("req_access", {31'h0, dmem_req}, 32'h1);
                check("we", {31'h0, dmem_we}, {31'h0, op == 4'd11});
                check("addr", {16'h0, dmem_addr}, {16'h0, res});
                check("wdata", {16'h0, dmem_wdata}, {16'h0, stv});
                check("stall_access", {31'h0, stall}, {31'h0, k != delay});
                exp_wb = (k == delay && op == 4'd10) ? {1'b1, dest, rd} : 20'h0;
            end
        end
    endtask

    task automatic reset_mid_access();
        @(negedge clock);
        exbus    = {1'b1, 4'd10, 3'd6, 16'h0123, 16'h0};
        dmem_ack = 1'b0;
        #1;
        check_regs();
        exp_wb = 20'h0;
        @(negedge clock);
        #1;
        check("req_before_rst", {31'h0, dmem_req}, 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check("req_in_rst", {31'h0, dmem_req}, 32'h0);
        check("stall_in_rst", {31'h0, stall}, 32'h0);
        check("wbbus_in_rst", {12'h0, wbbus}, 32'h0);
        exp_err = 1'b0;
        @(negedge clock);
        exbus  = '0;
        resetn = 1'b1;
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic run_timeout();
        @(negedge clock);
        exbus    = {1'b1, 4'd10, 3'd4, 16'h0200, 16'h0};
        dmem_ack = 1'b0;
        #1;
        check_regs();
        check("stall_to_idle", {31'h0, stall}, 32'h1);
        exp_wb = 20'h0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            #1;
            check_regs();
            check("req_to", {31'h0, dmem_req}, 32'h1);
            check("stall_to", {31'h0, stall}, {31'h0, k < 4});
        end
        exp_err = 1'b1;
    endtask
`endif

    initial begin
        exbus = {1'b1, 4'd10, 3'd1, 16'h0040, 16'h0};
        #12;
        check("rst_stall", {31'h0, stall}, 32'h0);
        check("rst_req", {31'h0, dmem_req}, 32'h0);
        check("rst_wbbus", {12'h0, wbbus}, 32'h0);
        check("rst_err", {31'h0, mem_err}, 32'h0);
        @(negedge clock);
        exbus  = '0;
        resetn = 1'b1;
        run_op(1'b1, 4'd1, 3'd3, 16'h1234, 16'h0, 0);
        run_op(1'b1, 4'd10, 3'd5, 16'h0040, 16'h0, 2);
        run_op(1'b1, 4'd11, 3'd2, 16'h0010, 16'hA5A5, 0);
        run_op(1'b1, 4'd1, 3'd7, 16'h5555, 16'h0, 0);
        run_op(1'b1, 4'd12, 3'd1, 16'hFFFF, 16'h1, 0);
        run_op(1'b1, 4'd0, 3'd2, 16'hAAAA, 16'h2, 0);
        run_op(1'b0, 4'd10, 3'd3, 16'h0100, 16'h3, 0);
        run_op(1'b1, 4'd10, 3'd1, 16'h0001, 16'h0, 0);
        run_op(1'b1, 4'd11, 3'd1, 16'h0002, 16'h9, 1);
        reset_mid_access();
        run_op(1'b1, 4'd1, 3'd2, 16'h4321, 16'h0, 0);
`ifdef MEM_TIMEOUT_EN
        run_timeout();
        run_op(1'b1, 4'd9, 3'd6, 16'h0F0F, 16'h0, 0);
`endif
        for (int i = 0; i < 300; i++) begin
            run_op(1'($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)), 3'($urandom),
                   16'($urandom), 16'($urandom), $urandom_range(0, 2));
        end
        run_op(1'b1, 4'd0, 3'd0, 16'h0, 16'h0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_module.md
# mem_module

Memory-access stage that sits directly downstream of the execute stage. It consumes the 40-bit execute result bus and performs LD/ST through a req/ack data-memory handshake. While an access is outstanding it stalls the upstream pipeline. It delivers a registered 20-bit writeback bus to the register-file stage.

## Interface
- TIMEOUT_CYCLES, 16: ACCESS cycles without ack before an abort. Only used with MEM_TIMEOUT_EN. Legal range 2..255.
- clock  in  1  pipeline clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- exbus  in  40  execute bus, fields as follows:
  - [39] valid
  - [38:35] op
  - [34:32] dest
  - [31:16] exresult
  - [15:0] stvalue
- stall  out  1  combinational; upstream holds exbus unchanged while high
- mem_dest  out  3  combinational copy of exbus[34:32], used for hazard detection
- dmem_req  out  1  memory request; equals (state==ACCESS)
- dmem_we  out  1  1 = store; valid while dmem_req
- dmem_addr  out  16  exbus exresult; valid while dmem_req
- dmem_wdata  out  16  exbus stvalue; valid while dmem_req
- dmem_rdata  in  16  load data; sampled in the cycle dmem_ack=1
- dmem_ack  in  1  access complete; single-cycle pulse
- wbbus  out  20  registered writeback bus:
  - [19] valid
  - [18:16] dest
  - [15:0] result
- mem_err  out  1  sticky timeout flag; constant 0 without MEM_TIMEOUT_EN

## Operation
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, OR=4, NOT=5, SL=6, SR=7, SRU=8, ADDI=9, LD=10, ST=11, BR=12.
- FSM states: IDLE, ACCESS.
- IDLE with exbus valid and op in 1..9:
  - wbbus <= {1, dest, exresult}.
  - stall=0.
- IDLE with exbus valid and op in {0, 11, 12}, or exbus invalid, or op 13..15:
  - wbbus valid <= 0.
  - stall=0, except for ST (see next rule).
- IDLE with exbus valid and op in {LD, ST}:
  - stall=1.
  - Next state ACCESS.
  - wbbus valid <= 0 (bubble).
- ACCESS, dmem_ack=0:
  - dmem_req=1, stall=1.
  - wbbus valid <= 0.
  - Address, write enable and write data are driven from the held exbus.
- ACCESS, dmem_ack=1:
  - stall=0, so upstream advances on this edge.
  - Next state IDLE.
  - LD: wbbus <= {1, dest, dmem_rdata}.
  - ST: wbbus valid <= 0.
- The instruction that follows enters on the next cycle; the minimum access is 2 cycles (IDLE, ACCESS).
- dmem_ack in IDLE is ignored.
- When wbbus valid=0, the dest and result fields are 0.

## Timing
- Reset values: state=IDLE, wbbus=0, mem_err=0, timeout counter=0.
- Resetn is asynchronous: dmem_req drops in the same cycle, including mid-access. A pending access is abandoned with no writeback.
- While resetn is low, stall and dmem_req are 0.
- Non-memory op: wbbus valid exactly 1 cycle after the op is present on exbus.
- LD: wbbus valid on the edge after the ack cycle. Latency = 1 + (ACCESS cycles until ack) clocks.
- Back-to-back LD/ST: the second op returns through IDLE, so there is one req-low cycle between accesses.

## Configuration
- MEM_TIMEOUT_EN defined: the ACCESS counter increments each cycle without ack and is cleared on entering ACCESS. When it reaches TIMEOUT_CYCLES-1 without ack, the block aborts:
  - stall=0 for that cycle.
  - Next state IDLE.
  - wbbus valid <= 0.
  - mem_err <= 1 and stays 1 until reset.
  - An ack arriving in the abort cycle wins: normal completion, no error.
- MEM_TIMEOUT_EN undefined: no counter. ACCESS waits indefinitely. mem_err is tied 0.

## Structure
- Shared package holds:
  - opcode constants, shared with the execute stage
  - exbus and wbbus widths and field bit positions
  - FSM state encoding
- Sub-module mem_watchdog: counter plus compare, instantiated only under MEM_TIMEOUT_EN.

## Test plan
- ADD, exbus={1,1,3,0x1234,0}: wbbus=0x3_1234 with valid=1 one cycle later; stall stays 0.
- LD dest=5 addr=0x0040, ack after 3 cycles with rdata=0xBEEF:
  - stall=1 for 3 cycles.
  - dmem_req high with addr=0x0040, we=0.
  - wbbus={1,5,0xBEEF} the cycle after ack.
- ST addr=0x0010 wdata=0xA5A5, ack after 1 cycle:
  - we=1, wdata=0xA5A5.
  - wbbus valid stays 0.
  - The next ADD appears on wbbus 2 cycles later.
- Resetn low during ACCESS: dmem_req, stall and wbbus go to 0 immediately. After release, an ADD completes normally.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, LD never acked:
  - abort after the 4th ACCESS cycle.
  - mem_err=1 and sticky.
  - no writeback; the following op proceeds.
- BR and NOP with valid=1, and a stray ack in IDLE: wbbus valid=0, no dmem_req, no state change.
